// File: rtl/mem_arb_pkg.sv
// Shared constants, slot type and round-robin helper for the memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned MEM_ARB_IDX_W  = 3;

  typedef struct packed {
    logic                     vld;
    logic [MEM_ARB_IDX_W-1:0] idx;
  } mem_arb_slot_t;

  function automatic logic [MEM_ARB_IDX_W-1:0] rr_next(input logic [MEM_ARB_IDX_W-1:0] idx,
                                                      input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-one finder: lowest set bit of req at or after ptr, with wrap.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic            vld,
  output logic [PtrW-1:0] idx
);

  always_comb begin
    logic [PtrW-1:0] j;
    vld = 1'b0;
    idx = '0;
    j   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = PtrW'((32'(ptr) + k) % N);
      if (!vld && req[j]) begin
        vld = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares two memory read ports and one write port among NUM_REQ requesters.
// Define MEM_ARB_FWD_EN for write-first read data on same-cycle address collisions.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W  = MEM_ARB_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0]         mem_read_address_0,
  output logic [ADDR_W-1:0]         mem_read_address_1,
  input  logic [DATA_W-1:0]         mem_read_data_0,
  input  logic [DATA_W-1:0]         mem_read_data_1,
  output logic [ADDR_W-1:0]         mem_write_address,
  output logic [DATA_W-1:0]         mem_write_data,
  output logic                      mem_write_enable
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IdxW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q [NUM_REQ];
  logic [DATA_W-1:0]  rsp_data_d [NUM_REQ];

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  logic [NUM_REQ-1:0] rd_req, wr_req, rd_req_s1;
  logic               s0_vld, s1_vld, w_vld;
  logic [IdxW-1:0]    s0_idx, s1_idx, w_idx;
  mem_arb_slot_t      slot0, slot1, wslot, last_rd;
  logic [DATA_W-1:0]  rdata_0, rdata_1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign addr_arr[g]                  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g]                 = req_wdata[g*DATA_W +: DATA_W];
    assign rsp_data[g*DATA_W +: DATA_W] = rsp_data_q[g];
  end

  assign rd_req = req_valid & ~req_write;
  assign wr_req = req_valid & req_write;

  // Slot 1 scans from the same pointer with slot 0 removed, so it lands on the next reader.
  always_comb begin
    rd_req_s1 = rd_req;
    if (s0_vld) rd_req_s1[s0_idx] = 1'b0;
  end

  rr_pick #(.N(NUM_REQ), .PtrW(IdxW)) u_pick_rd0 (
    .req (rd_req),
    .ptr (rd_ptr_q),
    .vld (s0_vld),
    .idx (s0_idx)
  );

  rr_pick #(.N(NUM_REQ), .PtrW(IdxW)) u_pick_rd1 (
    .req (rd_req_s1),
    .ptr (rd_ptr_q),
    .vld (s1_vld),
    .idx (s1_idx)
  );

  rr_pick #(.N(NUM_REQ), .PtrW(IdxW)) u_pick_wr (
    .req (wr_req),
    .ptr (wr_ptr_q),
    .vld (w_vld),
    .idx (w_idx)
  );

  assign slot0 = '{vld: s0_vld, idx: MEM_ARB_IDX_W'(s0_idx)};
  assign slot1 = '{vld: s1_vld, idx: MEM_ARB_IDX_W'(s1_idx)};
  assign wslot = '{vld: w_vld,  idx: MEM_ARB_IDX_W'(w_idx)};

  always_comb begin
    mem_read_address_0 = s0_vld ? addr_arr[s0_idx] : '0;
    mem_read_address_1 = s1_vld ? addr_arr[s1_idx] : '0;
    mem_write_address  = w_vld  ? addr_arr[w_idx]  : '0;
    mem_write_data     = w_vld  ? wdata_arr[w_idx] : '0;
    mem_write_enable   = w_vld & ~rst;
    req_ready          = '0;
    if (!rst) begin
      if (s0_vld) req_ready[s0_idx] = 1'b1;
      if (s1_vld) req_ready[s1_idx] = 1'b1;
      if (w_vld)  req_ready[w_idx]  = 1'b1;
    end
  end

`ifdef MEM_ARB_FWD_EN
  assign rdata_0 = (w_vld && (mem_write_address == mem_read_address_0)) ? mem_write_data
                                                                         : mem_read_data_0;
  assign rdata_1 = (w_vld && (mem_write_address == mem_read_address_1)) ? mem_write_data
                                                                         : mem_read_data_1;
`else
  assign rdata_0 = mem_read_data_0;
  assign rdata_1 = mem_read_data_1;
`endif

  always_comb begin
    last_rd  = slot1.vld ? slot1 : slot0;
    rd_ptr_d = rd_ptr_q;
    if (last_rd.vld) rd_ptr_d = IdxW'(rr_next(last_rd.idx, NUM_REQ));
    wr_ptr_d = wr_ptr_q;
    if (wslot.vld) wr_ptr_d = IdxW'(rr_next(wslot.idx, NUM_REQ));

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (s0_vld) begin
      rsp_valid_d[s0_idx] = 1'b1;
      rsp_data_d[s0_idx]  = rdata_0;
    end
    if (s1_vld) begin
      rsp_valid_d[s1_idx] = 1'b1;
      rsp_data_d[s1_idx]  = rdata_1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '{default: '0};
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;

endmodule
